color_palette_banked: RTL and testbench
=======================================

COLOR_PALETTE_BANKED -- requirements
Module: color_palette_banked

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 4, palette index width; legal range 1..6; depth N = 2**INDEX_WIDTH.
REQ-002 SHALL have parameter COLOR_WIDTH, default 10, color word width (YUV 4:3:3 at default).
REQ-003 SHALL have parameter VOID_COLOR, default 10'b0000_100_100 zero-extended/truncated to COLOR_WIDTH, reset value of entry 0.
REQ-004 SHALL have parameter DEFAULT_COLOR, default 10'b1111_100_100 sized to COLOR_WIDTH, reset value of entries 1..N-1.
REQ-005 clock_in  input  1  single clock; all state on rising edge.
REQ-006 reset_n_in  input  1  reset, asynchronous, active-low.
REQ-007 pixel_index_in  input  INDEX_WIDTH  lookup index.
REQ-008 pixel_valid_in  input  1  lookup strobe.
REQ-009 yuv_color_out  output  COLOR_WIDTH  looked-up color.
REQ-010 yuv_valid_out  output  1  yuv_color_out carries a new lookup result.
REQ-011 assign_color_enable_in  input  1  write request to shadow bank.
REQ-012 assign_color_index_in  input  INDEX_WIDTH  write address.
REQ-013 assign_color_value_in  input  COLOR_WIDTH  write data.
REQ-014 assign_ready_out  output  1  write accepted this cycle when high with enable.
REQ-015 swap_request_in  input  1  one-cycle pulse requesting bank swap.
REQ-016 frame_start_in  input  1  one-cycle pulse marking frame boundary.
REQ-017 swap_pending_out  output  1  swap requested or copy in progress.
REQ-018 active_bank_out  output  1  bank currently used for lookups.

Function
REQ-019 SHALL hold two banks of N entries x COLOR_WIDTH: active bank (lookups) and shadow bank (writes).
REQ-020 Lookup SHALL have 1-cycle latency: pixel_valid_in at edge k -> yuv_color_out = active[pixel_index_in], yuv_valid_out=1 after edge k.
REQ-021 pixel_valid_in low SHALL clear yuv_valid_out on the next edge and hold yuv_color_out.
REQ-022 assign_ready_out SHALL be high in IDLE and PENDING, low in COPY; a write SHALL occur only when enable && ready; writes while ready low SHALL be dropped.
REQ-023 State machine SHALL have IDLE, PENDING, COPY; swap_pending_out = (state != IDLE).
REQ-024 IDLE: swap_request_in -> PENDING next edge.
REQ-025 PENDING: frame_start_in -> active bank flips on that edge, copy counter cleared to 0, -> COPY; swap_request_in ignored.
REQ-026 COPY: each cycle shadow[count] <= active[count] (new active bank), count increments; after writing count = N-1 -> IDLE; COPY lasts exactly N cycles.
REQ-027 swap_request_in during COPY SHALL be latched; COPY exit then goes to PENDING instead of IDLE; the latch clears on entering PENDING.
REQ-028 frame_start_in in IDLE or COPY SHALL have no effect.
REQ-029 Lookup on the same edge as the swap SHALL read the old active bank; lookups from the next edge read the new one.
REQ-030 Write on the same edge as the swap (PENDING, frame_start_in) SHALL land in the old shadow bank, i.e. the bank becoming active, and SHALL be included in the subsequent copy.
REQ-031 Simultaneous lookup and write to the same index SHALL return the active-bank value (banks disjoint).

Reset
REQ-032 reset_n_in low SHALL immediately, without clock: entry 0 of both banks = VOID_COLOR, other entries = DEFAULT_COLOR, yuv_color_out = VOID_COLOR, yuv_valid_out = 0, active_bank_out = 0, state IDLE, copy counter 0, latched request cleared.
REQ-033 Reset asserted mid-COPY SHALL abort the copy and restore all REQ-032 values; assign_ready_out = 1 after release.

Verification
REQ-034 Reset then lookups of 0,1,15 (defaults) -> yuv_color_out 0x024 (VOID), 0x3E4, 0x3E4, each 1 cycle after valid.
REQ-035 Write index 3 = 0x155, lookup 3 -> still 0x3E4; swap_request, frame_start -> active_bank_out 1, lookup 3 -> 0x155 from next cycle.
REQ-036 After swap, assign_ready_out low exactly 16 cycles; write during COPY dropped; afterwards lookup/shadow entry 3 equals 0x155 after a second swap.
REQ-037 swap_request during COPY -> returns to PENDING with swap_pending_out held high; frame_start in IDLE -> active_bank_out unchanged.
REQ-038 Async reset asserted mid-COPY between clock edges -> outputs at REQ-032 values before next edge; INDEX_WIDTH=2, COLOR_WIDTH=8 instance repeats REQ-034/035 with COPY length 4.

Source files
------------

// File: rtl/color_palette_banked.sv
// Double-buffered colour palette. Lookups read the active bank and writes go to the shadow bank.
// A requested swap takes effect at the next frame start and then copies the new active bank back.
module color_palette_banked #(
   parameter int INDEX_WIDTH = 4,
   parameter int COLOR_WIDTH = 10,
   parameter logic [COLOR_WIDTH-1:0] VOID_COLOR    = COLOR_WIDTH'(10'b0000_100_100),
   parameter logic [COLOR_WIDTH-1:0] DEFAULT_COLOR = COLOR_WIDTH'(10'b1111_100_100)
) (
   input  logic                   clock_in,
   input  logic                   reset_n_in,
   input  logic [INDEX_WIDTH-1:0] pixel_index_in,
   input  logic                   pixel_valid_in,
   output logic [COLOR_WIDTH-1:0] yuv_color_out,
   output logic                   yuv_valid_out,
   input  logic                   assign_color_enable_in,
   input  logic [INDEX_WIDTH-1:0] assign_color_index_in,
   input  logic [COLOR_WIDTH-1:0] assign_color_value_in,
   output logic                   assign_ready_out,
   input  logic                   swap_request_in,
   input  logic                   frame_start_in,
   output logic                   swap_pending_out,
   output logic                   active_bank_out
);

   localparam int N = 1 << INDEX_WIDTH;
   localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(N - 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PENDING = 2'd1;
   localparam logic [1:0] ST_COPY    = 2'd2;

   logic [COLOR_WIDTH-1:0] mem [2][N];
   logic                   active_bank;
   logic [1:0]             state;
   logic [INDEX_WIDTH-1:0] copy_cnt;
   logic                   swap_latched;
   logic                   write_en;

   assign assign_ready_out = (state != ST_COPY);
   assign swap_pending_out = (state != ST_IDLE);
   assign active_bank_out  = active_bank;
   assign write_en         = assign_color_enable_in && assign_ready_out;

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N; i++) begin
               mem[b][i] <= (i == 0) ? VOID_COLOR : DEFAULT_COLOR;
            end
         end
         yuv_color_out <= VOID_COLOR;
         yuv_valid_out <= 1'b0;
         active_bank   <= 1'b0;
         state         <= ST_IDLE;
         copy_cnt      <= '0;
         swap_latched  <= 1'b0;
      end else begin
         // Lookup stage: reads the pre-edge active bank, so a swap on this edge is not yet visible
         yuv_valid_out <= pixel_valid_in;
         if (pixel_valid_in) begin
            yuv_color_out <= mem[active_bank][pixel_index_in];
         end
         // Shadow write uses the pre-edge bank select: on a swap edge it lands in the bank going active
         if (write_en) begin
            mem[~active_bank][assign_color_index_in] <= assign_color_value_in;
         end
         case (state)
            ST_IDLE: begin
               if (swap_request_in) begin
                  state <= ST_PENDING;
               end
            end
            ST_PENDING: begin
               if (frame_start_in) begin
                  active_bank <= ~active_bank;
                  copy_cnt    <= '0;
                  state       <= ST_COPY;
               end
            end
            ST_COPY: begin
               mem[~active_bank][copy_cnt] <= mem[active_bank][copy_cnt];
               copy_cnt <= copy_cnt + 1'b1;
               if (copy_cnt == LAST_IDX) begin
                  state        <= (swap_latched || swap_request_in) ? ST_PENDING : ST_IDLE;
                  swap_latched <= 1'b0;
               end else if (swap_request_in) begin
                  swap_latched <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_color_palette_banked.sv
// Bench for color_palette_banked: a 16x10 and a 4x8 instance driven with shared stimulus and
// compared every cycle against a bank/countdown model, plus hand-computed expectations.
module tb_color_palette_banked;

   logic       clk;
   logic       rst_n;
   logic       pv, we, swr, fs;
   logic [3:0] pidx, widx;
   logic [9:0] wval;

   logic [9:0] yout_a;
   logic       yvld_a, rdy_a, pend_a, act_a;
   logic [7:0] yout_b;
   logic       yvld_b, rdy_b, pend_b, act_b;

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;
   int low_a = 0;
   int low_b = 0;

   int nn[2]  = '{16, 4};
   int msk[2] = '{'h3FF, 'hFF};
   int mbank[2][2][16];
   int mact[2], mpend[2], mleft[2], mlatch[2], myout[2], myvld[2];

   color_palette_banked dut_a (
      .clock_in(clk), .reset_n_in(rst_n),
      .pixel_index_in(pidx), .pixel_valid_in(pv),
      .yuv_color_out(yout_a), .yuv_valid_out(yvld_a),
      .assign_color_enable_in(we), .assign_color_index_in(widx),
      .assign_color_value_in(wval), .assign_ready_out(rdy_a),
      .swap_request_in(swr), .frame_start_in(fs),
      .swap_pending_out(pend_a), .active_bank_out(act_a)
   );

   color_palette_banked #(.INDEX_WIDTH(2), .COLOR_WIDTH(8)) dut_b (
      .clock_in(clk), .reset_n_in(rst_n),
      .pixel_index_in(pidx[1:0]), .pixel_valid_in(pv),
      .yuv_color_out(yout_b), .yuv_valid_out(yvld_b),
      .assign_color_enable_in(we), .assign_color_index_in(widx[1:0]),
      .assign_color_value_in(wval[7:0]), .assign_ready_out(rdy_b),
      .swap_request_in(swr), .frame_start_in(fs),
      .swap_pending_out(pend_b), .active_bank_out(act_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < 16; i++)
               mbank[u][b][i] = (i == 0) ? 'h024 : ('h3E4 & msk[u]);
         myout[u] = 'h024; myvld[u] = 0;
         mact[u] = 0; mpend[u] = 0; mleft[u] = 0; mlatch[u] = 0;
      end
   endtask

   // Effect of the coming rising edge given the currently driven inputs
   task automatic model_step();
      int n, pi, wi, wv, k;
      for (int u = 0; u < 2; u++) begin
         n  = nn[u];
         pi = int'(pidx) & (n - 1);
         wi = int'(widx) & (n - 1);
         wv = int'(wval) & msk[u];
         myvld[u] = int'(pv);
         if (pv) myout[u] = mbank[u][mact[u]][pi];
         if (we && mleft[u] == 0) mbank[u][1 - mact[u]][wi] = wv;
         if (mleft[u] > 0) begin
            k = n - mleft[u];
            mbank[u][1 - mact[u]][k] = mbank[u][mact[u]][k];
            mleft[u]--;
            if (swr) mlatch[u] = 1;
            if (mleft[u] == 0 && mlatch[u] != 0) begin
               mpend[u] = 1;
               mlatch[u] = 0;
            end
         end else if (mpend[u] != 0) begin
            if (fs) begin
               mact[u] = 1 - mact[u];
               mpend[u] = 0;
               mleft[u] = n;
            end
         end else if (swr) begin
            mpend[u] = 1;
         end
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("yvld_a", yvld_a, myvld[0]);
         check("yout_a", yout_a, myout[0]);
         check("rdy_a",  rdy_a,  (mleft[0] == 0));
         check("pend_a", pend_a, (mpend[0] != 0 || mleft[0] > 0));
         check("act_a",  act_a,  mact[0]);
         check("yvld_b", yvld_b, myvld[1]);
         check("yout_b", yout_b, myout[1]);
         check("rdy_b",  rdy_b,  (mleft[1] == 0));
         check("pend_b", pend_b, (mpend[1] != 0 || mleft[1] > 0));
         check("act_b",  act_b,  mact[1]);
         if (!rdy_a) low_a++;
         if (!rdy_b) low_b++;
      end
   end

   // Called at a falling edge; drives, advances the model, returns at the next falling edge
   task automatic cyc(input logic p, input logic [3:0] pi, input logic w, input logic [3:0] wi,
                      input logic [9:0] wv, input logic s, input logic f);
      #1;
      pv = p; pidx = pi; we = w; widx = wi; wval = wv; swr = s; fs = f;
      model_step();
      @(negedge clk);
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check_reset_values();
      check("rst_yout_a", yout_a, 32'h024);
      check("rst_yvld_a", yvld_a, 0);
      check("rst_act_a",  act_a,  0);
      check("rst_pend_a", pend_a, 0);
      check("rst_rdy_a",  rdy_a,  1);
      check("rst_yout_b", yout_b, 32'h24);
      check("rst_pend_b", pend_b, 0);
   endtask

   // Asserts and releases reset between two rising edges
   task automatic mid_cycle_reset();
      #1;
      pv = 0; we = 0; swr = 0; fs = 0; pidx = 0; widx = 0; wval = 0;
      rst_n = 1'b0;
      #1;
      check_reset_values();
      model_reset();
      #1;
      rst_n = 1'b1;
      model_step();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      pv = 0; we = 0; swr = 0; fs = 0; pidx = 0; widx = 0; wval = 0;
      repeat (2) @(negedge clk);
      check_reset_values();
      model_reset();
      chk_en = 1;
      #1;
      rst_n = 1'b1;
      model_step();
      @(negedge clk);

      // Default contents
      cyc(1, 0, 0, 0, 0, 0, 0);
      check("lit_lookup0_a", yout_a, 32'h024);
      check("lit_lookup0_vld", yvld_a, 1);
      check("lit_lookup0_b", yout_b, 32'h24);
      cyc(1, 1, 0, 0, 0, 0, 0);
      check("lit_lookup1_a", yout_a, 32'h3E4);
      check("lit_lookup1_b", yout_b, 32'hE4);
      cyc(1, 15, 0, 0, 0, 0, 0);
      check("lit_lookup15_a", yout_a, 32'h3E4);
      check("lit_lookup15_b", yout_b, 32'hE4);

      // Shadow write does not disturb simultaneous lookup of the same index
      cyc(1, 3, 1, 3, 10'h155, 0, 0);
      check("lit_wr_same_idx_a", yout_a, 32'h3E4);
      check("lit_wr_same_idx_b", yout_b, 32'hE4);
      cyc(0, 0, 0, 0, 0, 1, 0);
      check("lit_pending_a", pend_a, 1);
      check("lit_hold_vld_a", yvld_a, 0);
      check("lit_hold_col_a", yout_a, 32'h3E4);
      low_a = 0; low_b = 0;
      cyc(0, 0, 0, 0, 0, 0, 1);
      check("lit_swap_act_a", act_a, 1);
      check("lit_swap_rdy_a", rdy_a, 0);
      cyc(1, 3, 1, 5, 10'h0AA, 0, 0);
      check("lit_new_bank_a", yout_a, 32'h155);
      check("lit_new_bank_b", yout_b, 32'h55);
      idle(20);
      check("lit_copy_len_a", low_a, 16);
      check("lit_copy_len_b", low_b, 4);
      check("lit_copy_done_pend_a", pend_a, 0);

      // Second swap: copied entry survives, write during copy was dropped
      cyc(0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      check("lit_swap2_act_a", act_a, 0);
      cyc(1, 3, 0, 0, 0, 0, 0);
      check("lit_copied3_a", yout_a, 32'h155);
      check("lit_copied3_b", yout_b, 32'h55);
      cyc(1, 5, 0, 0, 0, 0, 0);
      check("lit_dropped5_a", yout_a, 32'h3E4);
      check("lit_dropped1_b", yout_b, 32'hE4);

      // Request during copy re-enters PENDING
      cyc(0, 0, 0, 0, 0, 1, 0);
      idle(20);
      check("lit_latched_pend_a", pend_a, 1);
      check("lit_latched_rdy_a", rdy_a, 1);
      check("lit_latched_pend_b", pend_b, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      check("lit_swap3_act_a", act_a, 1);
      idle(20);
      cyc(0, 0, 0, 0, 0, 0, 1);
      check("lit_fs_idle_act_a", act_a, 1);
      check("lit_fs_idle_pend_a", pend_a, 0);

      // Reset in the middle of a copy
      cyc(0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(1, 3, 0, 0, 0, 0, 0);
      cyc(1, 3, 0, 0, 0, 0, 0);
      check("lit_pre_rst_rdy_a", rdy_a, 0);
      mid_cycle_reset();
      cyc(1, 3, 0, 0, 0, 0, 0);
      check("lit_post_rst_a", yout_a, 32'h3E4);
      check("lit_post_rst_b", yout_b, 32'hE4);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             10'($urandom_range(0, 1023)),
             ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
         if (i == 1500) mid_cycle_reset();
      end

      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
